amp_cfg_sequencer: RTL
======================

Name: amp_cfg_sequencer

Overview:
- Sequences the amplifier register configuration over the shared I2C write engine.
- Triggered by the amp state controller's send-config request. Walks an external configuration table of (register, data) pairs and issues one write per entry through a req/ack/done handshake.
- Retries NACKed or timed-out writes, enforces a settle gap between writes, and reports completion or failure back to the state controller.

Parameters:
- NUM_REGS, 8, number of table entries written per sequence (1..2^ADDR_W).
- ADDR_W, 4, table address width.
- MAX_RETRY, 3, retries per entry after the first attempt; total attempts = MAX_RETRY+1.
- GAP_CYCLES, 16, idle clk_in cycles between a completed write and the next fetch (0 is legal and skips the gap).
- TIMEOUT_CYCLES, 4096, cycles allowed from wr_ack to wr_done before the attempt counts as a NACK.

Ports:
- clk_in  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that starts a sequence.
- abort  input  1  level; forces a return to IDLE.
- rom_addr  output  ADDR_W  table address.
- rom_data  input  16  table word: [15:8] register, [7:0] data. Valid one cycle after rom_addr changes.
- wr_req  output  1  write request to the I2C master.
- wr_reg  output  8  register address for the write.
- wr_data  output  8  data byte for the write.
- wr_ack  input  1  one-cycle pulse; the master has accepted the request.
- wr_done  input  1  one-cycle pulse; the transfer has finished.
- wr_nack  input  1  sampled only in the wr_done cycle; 1 means the slave NACKed.
- busy  output  1  high in every state except IDLE, DONE and ERROR.
- cfg_done  output  1  sticky; all entries were written successfully.
- cfg_error  output  1  sticky; the retry limit was exhausted.
- err_index  output  ADDR_W  index of the failing entry; valid while cfg_error=1.

Behaviour:
- Reset (asynchronous, resetb=0): state IDLE. All outputs are 0, including rom_addr, wr_reg, wr_data and err_index. Index, retry and timer counters are cleared.
- States: IDLE, FETCH, LATCH, REQ, WAIT_DONE, GAP, DONE, ERROR.
- IDLE / DONE / ERROR:
  - start=1 -> FETCH; index=0, retry=0, cfg_done=0, cfg_error=0.
  - Otherwise hold the current state.
- FETCH: rom_addr=index. Next cycle -> LATCH.
- LATCH: wr_reg<=rom_data[15:8], wr_data<=rom_data[7:0] -> REQ.
- REQ:
  - wr_req=1; wr_reg and wr_data are held stable.
  - On wr_ack: wr_req drops the following cycle, timer clears -> WAIT_DONE.
  - wr_done arriving in REQ is ignored.
- WAIT_DONE: the timer increments each cycle.
  - Success (wr_done=1, wr_nack=0): retry=0 -> GAP.
  - Failure (wr_done=1 with wr_nack=1, or timer reaches TIMEOUT_CYCLES-1):
    - If retry<MAX_RETRY: retry+=1 -> GAP, then the same index is re-issued.
    - Otherwise: err_index=index, cfg_error=1 -> ERROR.
- GAP:
  - Counts GAP_CYCLES cycles.
  - After a success: if index==NUM_REGS-1, cfg_done=1 -> DONE; otherwise index+=1 -> FETCH.
  - After a failed attempt with retries left: -> FETCH with the same index.
  - With GAP_CYCLES=0, GAP lasts exactly 1 cycle.
- Minimum cycles per successful entry (zero-latency master): FETCH 1 + LATCH 1 + REQ 1 + WAIT_DONE ≥1 + GAP max(GAP_CYCLES,1).
- abort=1 in any state: next cycle -> IDLE.
  - wr_req=0, busy=0; cfg_done and cfg_error are unchanged; counters are cleared.
  - abort has priority over start, wr_ack and wr_done in the same cycle.
- start while busy=1 is ignored.
- An unsolicited wr_ack, or wr_done/wr_nack outside WAIT_DONE, is ignored.
- The index never wraps: NUM_REGS-1 is terminal.
- The retry counter is sized for MAX_RETRY. The timer is sized for TIMEOUT_CYCLES and saturates.
- resetb asserted mid-transfer: wr_req drops immediately (asynchronous). The master is responsible for its own bus recovery.

Test Plan:
- Nominal sequence (NUM_REGS=8, GAP_CYCLES=16, master acks after 2 cycles, done after 100 cycles, no NACK) -> exactly 8 writes matching table words 0..7 in order. cfg_done=1 and busy=0 after the last GAP; cfg_error=0; wr_reg/wr_data are stable during each wr_req.
- Single NACK at entry 3 (first attempt only) -> entry 3 is issued twice; all 8 entries complete; cfg_done=1; 9 wr_req assertions in total.
- Persistent NACK at entry 5 (MAX_RETRY=3) -> entry 5 is issued 4 times; cfg_error=1, err_index=5, cfg_done=0; no write of entry 6.
- Timeout: wr_done never arrives for entry 0 (TIMEOUT_CYCLES=64) -> 4 attempts spaced ≥64+GAP cycles apart, then cfg_error=1, err_index=0.
- Abort during WAIT_DONE of entry 2 -> IDLE next cycle, wr_req=0, busy=0. A following start restarts from entry 0 and completes with cfg_done=1.
- Mixed events: start while busy -> no restart and index unaffected. abort and wr_done in the same cycle -> IDLE with no index advance. resetb pulsed mid-REQ -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/amp_cfg_sequencer.sv
// Amplifier configuration sequencer: walks a (register, data) table and issues
// one I2C write per entry, with retry, write timeout and inter-write settle gap.
module amp_cfg_sequencer #(
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_in,
  input  logic              resetb,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              wr_req,
  output logic [7:0]        wr_reg,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  input  logic              wr_done,
  input  logic              wr_nack,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ADDR_W-1:0] err_index
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0]  IDX_LAST   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_REQ, S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [RETRY_W-1:0] retry_q;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q;
  logic               ok_q;
  logic [ADDR_W-1:0]  rom_addr_q, err_index_q;
  logic               wr_req_q, cfg_done_q, cfg_error_q;
  logic [7:0]         wr_reg_q, wr_data_q;

  assign timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      ok_q        <= 1'b0;
      rom_addr_q  <= '0;
      err_index_q <= '0;
      wr_req_q    <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      cfg_done_q  <= 1'b0;
      cfg_error_q <= 1'b0;
    end else if (abort) begin
      state_q  <= S_IDLE;
      wr_req_q <= 1'b0;
      idx_q    <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      gap_q    <= '0;
      ok_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q     <= S_FETCH;
            idx_q       <= '0;
            retry_q     <= '0;
            rom_addr_q  <= '0;
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          wr_reg_q  <= rom_data[15:8];
          wr_data_q <= rom_data[7:0];
          wr_req_q  <= 1'b1;
          state_q   <= S_REQ;
        end
        S_REQ: begin
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            timer_q  <= '0;
            state_q  <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          timer_q <= timer_d;
          // A real wr_done wins over a timeout expiring in the same cycle.
          if (wr_done && !wr_nack) begin
            retry_q <= '0;
            ok_q    <= 1'b1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end else if (wr_done || timer_q == TIMER_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + 1'b1;
              ok_q    <= 1'b0;
              gap_q   <= '0;
              state_q <= S_GAP;
            end else begin
              err_index_q <= idx_q;
              cfg_error_q <= 1'b1;
              state_q     <= S_ERROR;
            end
          end
        end
        S_GAP: begin
          if (gap_q >= GAP_LAST) begin
            if (!ok_q) begin
              rom_addr_q <= idx_q;
              state_q    <= S_FETCH;
            end else if (idx_q == IDX_LAST) begin
              cfg_done_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              idx_q      <= idx_q + 1'b1;
              rom_addr_q <= idx_q + 1'b1;
              state_q    <= S_FETCH;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign rom_addr  = rom_addr_q;
  assign wr_req    = wr_req_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_error = cfg_error_q;
  assign err_index = err_index_q;

endmodule
